// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use and branch-operand hazard detection with stall/flush control
// A 2-state FSM stretches load-use stalls to LOAD_LAT cycles; a saturating counter tracks stalled cycles.
module hazard_ctrl #(
   parameter int REG_W    = 5,
   parameter int LOAD_LAT = 1,
   parameter int BR_IN_ID = 1,
   parameter int CNT_W    = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [31:0]      instr_i,
   input  logic             idex_memread_i,
   input  logic             idex_regwrite_i,
   input  logic [REG_W-1:0] idex_rd_i,
   input  logic             exmem_memread_i,
   input  logic [REG_W-1:0] exmem_rd_i,
   input  logic             branch_i,
   input  logic             branch_taken_i,
   output logic             pc_write_o,
   output logic             ifid_write_o,
   output logic             bubble_o,
   output logic             ifid_flush_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   if (LOAD_LAT < 1 || LOAD_LAT > 4) begin : g_bad_load_lat
      $error("hazard_ctrl: LOAD_LAT must be in 1..4");
   end

   typedef enum logic {IDLE, HOLD} state_t;

   state_t           state_q, state_d;
   logic [2:0]       rem_q, rem_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [5:0]       op;
   logic [REG_W-1:0] rs, rt;
   logic             use_rs, use_rt;
   logic             idex_hit, exmem_hit;
   logic             load_haz, br_haz;
   logic             stall;
   logic             unused_instr;

   assign op     = instr_i[31:26];
   assign rs     = REG_W'(instr_i[25:21]);
   assign rt     = REG_W'(instr_i[20:16]);
   assign use_rs = (op != 6'h02);
   assign use_rt = (op == 6'h00) || (op == 6'h04) || (op == 6'h2B);
   assign unused_instr = ^instr_i[15:0];

   // $0 is hard-wired, so a producer targeting it never creates a dependency
   assign idex_hit  = (idex_rd_i != '0) &&
                      ((use_rs && (idex_rd_i == rs)) || (use_rt && (idex_rd_i == rt)));
   assign exmem_hit = (exmem_rd_i != '0) &&
                      ((use_rs && (exmem_rd_i == rs)) || (use_rt && (exmem_rd_i == rt)));

   assign load_haz = idex_memread_i & idex_hit;
   assign br_haz   = (BR_IN_ID != 0) & branch_i &
                     ((idex_regwrite_i & idex_hit) | (exmem_memread_i & exmem_hit));

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      stall   = 1'b0;
      case (state_q)
         IDLE: begin
            stall = load_haz | br_haz;
            if (load_haz && (LOAD_LAT > 1)) begin
               state_d = HOLD;
               rem_d   = 3'(LOAD_LAT - 1);
            end
         end
         HOLD: begin
            stall = 1'b1;
            rem_d = rem_q - 3'd1;
            if (rem_q == 3'd1) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            rem_d   = 3'd0;
         end
      endcase
   end

   assign cnt_d = (stall && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         rem_q   <= 3'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
      end
   end

   // While reset is held the pipeline must run freely regardless of hazard inputs
   assign pc_write_o   = ~(rst_i & stall);
   assign ifid_write_o = ~(rst_i & stall);
   assign bubble_o     = rst_i & stall;
   assign ifid_flush_o = rst_i & branch_taken_i & ~stall;
   assign stall_cnt_o  = cnt_q;

endmodule
